nes_btn_events: RTL and testbench

Downstream consumer of the NES controller scanner's 8-bit button vector. Debounces the raw active-low vector into an active-high held-button state. Generates press, release and auto-repeat events into a small first-word-fall-through event FIFO. The MicroBlaze/AXI wrapper drains the FIFO, so software sees discrete button events instead of polling levels.

---
 rtl/nes_btn_events_pkg.sv | 41 ++++
 rtl/nes_evt_fifo.sv | 62 ++++++
 rtl/nes_btn_events.sv | 186 ++++++++++++++++++
 tb/tb_nes_btn_events.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nes_btn_events_pkg.sv
// nes_btn_events_pkg: shared definitions for the NES button event block.
//   - evt_type_e : event type codes carried in evt_data[4:3]
//   - BTN_*      : bit positions of each button in the scanner vector
//   - top_idx    : index of the highest set bit of an 8-bit vector
//   - onehot4    : true when exactly one bit of a 4-bit vector is set
package nes_btn_events_pkg;

    typedef enum logic [1:0] {
        EVT_PRESS   = 2'b00,
        EVT_RELEASE = 2'b01,
        EVT_REPEAT  = 2'b10
    } evt_type_e;

    localparam int BTN_A      = 7;
    localparam int BTN_B      = 6;
    localparam int BTN_SELECT = 5;
    localparam int BTN_START  = 4;
    localparam int BTN_UP     = 3;
    localparam int BTN_DOWN   = 2;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_RIGHT  = 0;

    localparam int EVT_W = 5;

    // Highest set bit wins, so later (higher) indices overwrite earlier ones.
    function automatic logic [2:0] top_idx(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                r = i[2:0];
            end
        end
        return r;
    endfunction

    function automatic logic onehot4(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

endpackage

// File: rtl/nes_evt_fifo.sv
// nes_evt_fifo: synchronous first-word-fall-through FIFO.
//   clk, reset (sync, active-low)
//   push, push_data : write request; ignored when full unless popping too
//   pop             : read request; ignored when empty
//   head            : oldest entry, valid whenever empty is low
//   full, empty     : status from extra-MSB pointer comparison
module nes_evt_fifo
    import nes_btn_events_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             wr_en_s;
    logic             rd_en_s;

    // Status flags and qualified read/write enables.
    always_comb begin
        empty   = (wr_ptr_r == rd_ptr_r);
        full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                  (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        // A full FIFO still accepts a write when the head leaves this cycle.
        wr_en_s = push && (!full || pop);
        rd_en_s = pop && !empty;
    end

    assign head = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer and storage update; storage is cleared so head reads 0 after reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= push_data;
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/nes_btn_events.sv
// nes_btn_events: debounces the NES scanner vector and queues button events.
//   clk, reset (sync, active-low)
//   nes_btns     : raw active-low vector {A,B,Select,Start,Up,Down,Left,Right}
//   btn_state    : debounced active-high held state
//   evt_data     : FIFO head {type[1:0], idx[2:0]}
//   evt_valid    : FIFO non-empty
//   evt_ready    : consumer pop (pop when evt_valid && evt_ready)
//   evt_overflow : sticky drop flag, cleared by clr_overflow
module nes_btn_events
    import nes_btn_events_pkg::*;
#(
    parameter int CNTR_WIDTH          = 32,
    parameter int DEBOUNCE_CYCLES     = 1500000,
    parameter int REPEAT_DELAY_CYCLES = 50000000,
    parameter int REPEAT_RATE_CYCLES  = 10000000,
    parameter int FIFO_DEPTH          = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] nes_btns,
    output logic [7:0] btn_state,
    output logic [4:0] evt_data,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic       evt_overflow,
    input  logic       clr_overflow
);

    localparam logic [CNTR_WIDTH-1:0] DEB_MAX    = CNTR_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNTR_WIDTH-1:0] REP_MAX    = CNTR_WIDTH'(REPEAT_DELAY_CYCLES - 1);
    // Reloading to DELAY-RATE puts the next terminal count RATE cycles away.
    localparam logic [CNTR_WIDTH-1:0] REP_RELOAD = CNTR_WIDTH'(REPEAT_DELAY_CYCLES - REPEAT_RATE_CYCLES);
    localparam logic [CNTR_WIDTH-1:0] CNT_ONE    = CNTR_WIDTH'(1);

    logic [7:0]            cand_r;
    logic [CNTR_WIDTH-1:0] cnt_r;
    logic [7:0]            btn_state_r;
    logic                  primed_r;
    logic [7:0]            press_pend_r, rel_pend_r;
    logic [3:0]            rep_pend_r;
    logic [CNTR_WIDTH-1:0] rcnt_r;
    logic                  ovf_r;

    logic                  commit_s;
    logic [7:0]            new_state_s;
    logic                  push_s, pop_s, drop_s;
    logic [4:0]            evt_s;
    logic [2:0]            idx_s;
    logic [7:0]            press_clr_s, rel_clr_s;
    logic [3:0]            rep_clr_s;
    logic                  rep_fire_s;
    logic [CNTR_WIDTH-1:0] rcnt_nxt_s;
    logic [7:0]            press_nxt_s, rel_nxt_s;
    logic [3:0]            rep_nxt_s;
    logic                  fifo_full_s, fifo_empty_s;

    // Commit decision; the first commit after reset always fires so that an
    // all-released vector still primes the block.
    always_comb begin
        new_state_s = ~cand_r;
        commit_s    = (cnt_r == DEB_MAX) && (!primed_r || (new_state_s != btn_state_r));
    end

    // Emitter: one event per cycle, press > release > repeat, high index first.
    always_comb begin
        push_s      = 1'b0;
        idx_s       = 3'd0;
        evt_s       = 5'd0;
        press_clr_s = 8'h00;
        rel_clr_s   = 8'h00;
        rep_clr_s   = 4'h0;
        if (|press_pend_r) begin
            push_s = 1'b1;
            idx_s  = top_idx(press_pend_r);
            evt_s  = {EVT_PRESS, idx_s};
            press_clr_s[idx_s] = 1'b1;
        end else if (|rel_pend_r) begin
            push_s = 1'b1;
            idx_s  = top_idx(rel_pend_r);
            evt_s  = {EVT_RELEASE, idx_s};
            rel_clr_s[idx_s] = 1'b1;
        end else if (|rep_pend_r) begin
            push_s = 1'b1;
            idx_s  = top_idx({4'b0000, rep_pend_r});
            evt_s  = {EVT_REPEAT, idx_s};
            rep_clr_s[idx_s[1:0]] = 1'b1;
        end else begin
            push_s = 1'b0;
        end
    end

    // Auto-repeat counter: runs only while exactly one direction is held.
    always_comb begin
        rcnt_nxt_s = rcnt_r;
        rep_fire_s = 1'b0;
        if (commit_s || !onehot4(btn_state_r[BTN_UP:BTN_RIGHT])) begin
            rcnt_nxt_s = '0;
        end else if (rcnt_r == REP_MAX) begin
            rcnt_nxt_s = REP_RELOAD;
            rep_fire_s = 1'b1;
        end else begin
            rcnt_nxt_s = rcnt_r + CNT_ONE;
        end
    end

    // Pending-bit update: emitted bits clear, primed commits add edges.
    always_comb begin
        press_nxt_s = press_pend_r & ~press_clr_s;
        rel_nxt_s   = rel_pend_r & ~rel_clr_s;
        rep_nxt_s   = rep_pend_r & ~rep_clr_s;
        if (rep_fire_s) begin
            rep_nxt_s = rep_nxt_s | btn_state_r[BTN_UP:BTN_RIGHT];
        end else begin
            rep_nxt_s = rep_nxt_s;
        end
        if (commit_s && primed_r) begin
            press_nxt_s = press_nxt_s | (new_state_s & ~btn_state_r);
            rel_nxt_s   = rel_nxt_s | (~new_state_s & btn_state_r);
            // A direction released before its repeat went out loses the repeat.
            rep_nxt_s   = rep_nxt_s & new_state_s[BTN_UP:BTN_RIGHT];
        end else begin
            press_nxt_s = press_nxt_s;
        end
    end

    // Pop / drop qualification.
    always_comb begin
        pop_s  = !fifo_empty_s && evt_ready;
        drop_s = push_s && fifo_full_s && !pop_s;
    end

    // Debounce, held state, pending events, repeat counter and overflow flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cand_r       <= 8'hFF;
            cnt_r        <= '0;
            btn_state_r  <= 8'h00;
            primed_r     <= 1'b0;
            press_pend_r <= 8'h00;
            rel_pend_r   <= 8'h00;
            rep_pend_r   <= 4'h0;
            rcnt_r       <= '0;
            ovf_r        <= 1'b0;
        end else begin
            if (nes_btns != cand_r) begin
                cand_r <= nes_btns;
                cnt_r  <= '0;
            end else if (cnt_r != DEB_MAX) begin
                cnt_r <= cnt_r + CNT_ONE;
            end
            if (commit_s) begin
                btn_state_r <= new_state_s;
                primed_r    <= 1'b1;
            end
            press_pend_r <= press_nxt_s;
            rel_pend_r   <= rel_nxt_s;
            rep_pend_r   <= rep_nxt_s;
            rcnt_r       <= rcnt_nxt_s;
            // A new drop wins over a simultaneous clear.
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (clr_overflow) begin
                ovf_r <= 1'b0;
            end
        end
    end

    nes_evt_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (evt_s),
        .pop       (pop_s),
        .head      (evt_data),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    assign btn_state    = btn_state_r;
    assign evt_valid    = !fifo_empty_s;
    assign evt_overflow = ovf_r;

endmodule

// File: tb/tb_nes_btn_events.sv
module tb_nes_btn_events;
    import nes_btn_events_pkg::*;

    localparam int D = 4, DLY = 20, RATE = 8, DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] nes_btns = 8'hFF;
    logic [7:0] btn_state;
    logic [4:0] evt_data;
    logic       evt_valid;
    logic       evt_ready = 1'b1;
    logic       evt_overflow;
    logic       clr_overflow = 1'b0;

    nes_btn_events #(
        .CNTR_WIDTH          (32),
        .DEBOUNCE_CYCLES     (D),
        .REPEAT_DELAY_CYCLES (DLY),
        .REPEAT_RATE_CYCLES  (RATE),
        .FIFO_DEPTH          (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .nes_btns     (nes_btns),
        .btn_state    (btn_state),
        .evt_data     (evt_data),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_overflow (evt_overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Every consumed event (valid && ready) is logged with its cycle number.
    int         log_cyc[$];
    logic [4:0] log_dat[$];
    always @(negedge clk) begin
        if (evt_valid && evt_ready) begin
            log_cyc.push_back(cyc);
            log_dat.push_back(evt_data);
        end
    end

    // Expected event stream for hand sequences (cycle -1 = don't care).
    int         exp_cyc[$];
    logic [4:0] exp_dat[$];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    function automatic logic [4:0] ev(input logic [1:0] t, input int i);
        logic [2:0] i3;
        i3 = i[2:0];
        return {t, i3};
    endfunction

    task automatic clear_logs();
        log_cyc.delete();
        log_dat.delete();
        exp_cyc.delete();
        exp_dat.delete();
    endtask

    task automatic chk_log(input string name);
        chk({name, "_count"}, log_dat.size(), exp_dat.size());
        for (int i = 0; i < exp_dat.size() && i < log_dat.size(); i++) begin
            chk($sformatf("%s_data%0d", name, i), log_dat[i], exp_dat[i]);
            if (exp_cyc[i] >= 0)
                chk($sformatf("%s_cyc%0d", name, i), log_cyc[i], exp_cyc[i]);
        end
    endtask

    // Reference: events implied by moving the held state from old_s to new_s.
    task automatic add_diff_events(input logic [7:0] old_s, input logic [7:0] new_s);
        for (int i = 7; i >= 0; i--)
            if (new_s[i] && !old_s[i]) begin exp_dat.push_back(ev(EVT_PRESS, i)); exp_cyc.push_back(-1); end
        for (int i = 7; i >= 0; i--)
            if (!new_s[i] && old_s[i]) begin exp_dat.push_back(ev(EVT_RELEASE, i)); exp_cyc.push_back(-1); end
    endtask

    typedef struct {
        logic [7:0]      btns;
        logic [7:0]      exp_state;
        int              n;
        logic [2:0][4:0] evts;
    } vec_t;

    vec_t tbl[7];

    function automatic logic [2:0][4:0] mk3(input logic [4:0] e0, input logic [4:0] e1, input logic [4:0] e2);
        logic [2:0][4:0] r;
        r[0] = e0; r[1] = e1; r[2] = e2;
        return r;
    endfunction

    initial begin
        int t0;
        logic [7:0] model_state;
        logic [7:0] v;
        int h;

        tbl[0] = '{8'h7F, 8'h80, 1, mk3(ev(EVT_PRESS, BTN_A), 5'd0, 5'd0)};
        tbl[1] = '{8'hFF, 8'h00, 1, mk3(ev(EVT_RELEASE, BTN_A), 5'd0, 5'd0)};
        tbl[2] = '{8'h3E, 8'hC1, 3, mk3(ev(EVT_PRESS, BTN_A), ev(EVT_PRESS, BTN_B), ev(EVT_PRESS, BTN_RIGHT))};
        tbl[3] = '{8'h7D, 8'h82, 3, mk3(ev(EVT_PRESS, BTN_LEFT), ev(EVT_RELEASE, BTN_B), ev(EVT_RELEASE, BTN_RIGHT))};
        tbl[4] = '{8'hFF, 8'h00, 2, mk3(ev(EVT_RELEASE, BTN_A), ev(EVT_RELEASE, BTN_LEFT), 5'd0)};
        tbl[5] = '{8'hFE, 8'h01, 1, mk3(ev(EVT_PRESS, BTN_RIGHT), 5'd0, 5'd0)};
        tbl[6] = '{8'hFF, 8'h00, 1, mk3(ev(EVT_RELEASE, BTN_RIGHT), 5'd0, 5'd0)};

        // Reset state.
        tick(2);
        chk("rst_btn_state", btn_state, 8'h00);
        chk("rst_evt_valid", evt_valid, 1'b0);
        chk("rst_evt_data", evt_data, 5'd0);
        chk("rst_overflow", evt_overflow, 1'b0);

        // Prime with everything released: no events.
        reset = 1'b1;
        clear_logs();
        tick(10);
        chk("prime_state", btn_state, 8'h00);
        chk_log("prime");

        // Table: single, release and simultaneous changes with exact timing.
        for (int k = 0; k < 7; k++) begin
            clear_logs();
            t0 = cyc;
            nes_btns = tbl[k].btns;
            for (int j = 0; j < tbl[k].n; j++) begin
                exp_dat.push_back(tbl[k].evts[j]);
                exp_cyc.push_back(t0 + D + 2 + j);
            end
            tick(12);
            chk($sformatf("tbl%0d_state", k), btn_state, tbl[k].exp_state);
            chk_log($sformatf("tbl%0d", k));
        end

        // Bounce FF/BF every 2 cycles, then settle on BF.
        clear_logs();
        for (int p = 0; p < 10; p++) begin
            nes_btns = (p % 2 == 0) ? 8'hBF : 8'hFF;
            tick(2);
        end
        t0 = cyc;
        nes_btns = 8'hBF;
        exp_dat.push_back(ev(EVT_PRESS, BTN_B)); exp_cyc.push_back(t0 + D + 2);
        tick(12);
        chk_log("bounce");
        chk("bounce_state", btn_state, 8'h40);
        nes_btns = 8'hFF;
        tick(12);

        // Hold Up: press, repeat after the delay, then at the rate; Left stops it.
        clear_logs();
        t0 = cyc;
        nes_btns = 8'hF7;
        exp_dat.push_back(ev(EVT_PRESS, BTN_UP));  exp_cyc.push_back(t0 + D + 2);
        exp_dat.push_back(ev(EVT_REPEAT, BTN_UP)); exp_cyc.push_back(t0 + D + 1 + DLY + 1);
        exp_dat.push_back(ev(EVT_REPEAT, BTN_UP)); exp_cyc.push_back(t0 + D + 1 + DLY + 1 + RATE);
        exp_dat.push_back(ev(EVT_REPEAT, BTN_UP)); exp_cyc.push_back(t0 + D + 1 + DLY + 1 + 2 * RATE);
        tick(43);
        nes_btns = 8'hF5;
        exp_dat.push_back(ev(EVT_PRESS, BTN_LEFT)); exp_cyc.push_back(t0 + 43 + D + 2);
        tick(30);
        chk_log("repeat");
        chk("repeat_state", btn_state, 8'h0A);
        nes_btns = 8'hFF;
        tick(12);

        // Overflow: six presses into a four-entry FIFO with no consumer.
        clear_logs();
        evt_ready = 1'b0;
        nes_btns = 8'h03;
        tick(15);
        chk("ovf_flag", evt_overflow, 1'b1);
        chk("ovf_valid", evt_valid, 1'b1);
        chk("ovf_head_stable", evt_data, ev(EVT_PRESS, BTN_A));
        evt_ready = 1'b1;
        for (int i = 7; i >= 4; i--) begin exp_dat.push_back(ev(EVT_PRESS, i)); exp_cyc.push_back(-1); end
        tick(4);
        evt_ready = 1'b0;
        chk_log("ovf");
        chk("ovf_drained", evt_valid, 1'b0);
        chk("ovf_sticky", evt_overflow, 1'b1);
        clr_overflow = 1'b1;
        tick(1);
        clr_overflow = 1'b0;
        chk("ovf_cleared", evt_overflow, 1'b0);

        // Reset with three releases queued: queue discarded, silent re-prime.
        nes_btns = 8'hE3;
        tick(12);
        chk("rst_mid_queued", evt_valid, 1'b1);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        chk("rst_mid_valid", evt_valid, 1'b0);
        chk("rst_mid_state", btn_state, 8'h00);
        clear_logs();
        evt_ready = 1'b1;
        tick(20);
        chk_log("reprime");
        chk("reprime_state", btn_state, 8'h1C);

        // Randomized: glitches shorter than the debounce window, stable holds
        // short enough that no single direction reaches the repeat delay.
        nes_btns = 8'hFF;
        tick(14);
        clear_logs();
        model_state = 8'h00;
        for (int s = 0; s < 40; s++) begin
            if ($urandom_range(1, 0) == 1) begin
                nes_btns = 8'($urandom);
                tick($urandom_range(D - 1, 1));
            end
            do v = 8'($urandom); while (~v == model_state);
            nes_btns = v;
            add_diff_events(model_state, ~v);
            model_state = ~v;
            h = $urandom_range(14, 9);
            tick(h);
            chk($sformatf("rnd%0d_state", s), btn_state, model_state);
        end
        nes_btns = 8'hFF;
        add_diff_events(model_state, 8'h00);
        tick(20);
        chk_log("rnd");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
